conway_frame_renderer: RTL and testbench

//   Downstream stage of the Life engine: on a start pulse, walks the board RAM row-major and

---
 rtl/conway_term_pkg.sv | 31 +++
 rtl/conway_esc_rom.sv | 35 +++
 rtl/conway_frame_renderer.sv | 250 +++++++++++++++++++++++++
 tb/tb_conway_frame_renderer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conway_term_pkg.sv
// Shared render FSM encoding, escape-sequence identifiers and ASCII constants for the frame renderer.
// Optional colour attribute tracking is enabled by defining CONWAY_RENDER_COLOR_EN.
package conway_term_pkg;

  typedef enum logic [2:0] {
    RS_IDLE,
    RS_HOME,
    RS_ATTR,
    RS_FETCH,
    RS_WAIT,
    RS_CELL,
    RS_EOL,
    RS_TAIL
  } render_state_e;

  typedef enum logic [1:0] {
    SEQ_HOME,
    SEQ_SGR0,
    SEQ_SGR7
  } esc_seq_e;

  localparam logic [7:0] ESC  = 8'h1B;
  localparam logic [7:0] LBR  = 8'h5B;
  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_M = 8'h6D;
  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_7 = 8'h37;
  localparam logic [7:0] CR   = 8'h0D;
  localparam logic [7:0] LF   = 8'h0A;

endpackage

// File: rtl/conway_esc_rom.sv
// Combinational lookup of the terminal escape sequences: ESC[H, ESC[0m and ESC[7m.
// Returns the byte at position idx and flags the final byte of the selected sequence.
module conway_esc_rom
  import conway_term_pkg::*;
(
  input  esc_seq_e    seq_id,
  input  logic [1:0]  idx,
  output logic [7:0]  esc_byte,
  output logic        last
);

  always_comb begin
    esc_byte = ESC;
    last     = 1'b0;
    case (idx)
      2'd0: esc_byte = ESC;
      2'd1: esc_byte = LBR;
      2'd2: begin
        case (seq_id)
          SEQ_HOME: begin
            esc_byte = CH_H;
            last     = 1'b1;
          end
          SEQ_SGR0: esc_byte = CH_0;
          default:  esc_byte = CH_7;
        endcase
      end
      default: begin
        esc_byte = CH_M;
        last     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/conway_frame_renderer.sv
// Streams one terminal frame (cursor home, then BOARD_H rows of glyphs + CR LF) from the board RAM to a UART.
// Defining CONWAY_RENDER_COLOR_EN adds reverse-video SGR attribute tracking around live cells.
module conway_frame_renderer
  import conway_term_pkg::*;
#(
  parameter int         BOARD_W    = 32,
  parameter int         BOARD_H    = 16,
  parameter logic [7:0] CHAR_ALIVE = 8'h2A,
  parameter logic [7:0] CHAR_DEAD  = 8'h20,
  localparam int        ADDR_W     = $clog2(BOARD_W * BOARD_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              cell_rd_en,
  output logic [ADDR_W-1:0] cell_addr,
  input  logic              cell_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int COL_W = $clog2(BOARD_W);
  localparam int ROW_W = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;

  render_state_e      state_q, state_d;
  esc_seq_e           seq_q, seq_d;
  logic [1:0]         idx_q, idx_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               cell_q, cell_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
`ifdef CONWAY_RENDER_COLOR_EN
  logic               attr_q, attr_d;
`endif

  logic       sent;
  logic       emit_en;
  logic [7:0] emit_byte;
  logic       finish;
  logic [7:0] rom_byte;
  logic       rom_last;

  conway_esc_rom u_esc_rom (
    .seq_id   (seq_q),
    .idx      (idx_q),
    .esc_byte (rom_byte),
    .last     (rom_last)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign cell_addr = ADDR_W'(32'(row_q) * BOARD_W + 32'(col_q));

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    idx_d      = idx_q;
    row_d      = row_q;
    col_d      = col_q;
    cell_d     = cell_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
`ifdef CONWAY_RENDER_COLOR_EN
    attr_d     = attr_q;
`endif
    cell_rd_en = 1'b0;
    emit_en    = 1'b0;
    emit_byte  = CHAR_DEAD;
    finish     = 1'b0;
    sent       = tx_valid_q && tx_ready;

    case (state_q)
      RS_IDLE: begin
        if (start) begin
          state_d = RS_HOME;
          seq_d   = SEQ_HOME;
          idx_d   = 2'd0;
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b1;
`ifdef CONWAY_RENDER_COLOR_EN
          attr_d  = 1'b0;
`endif
        end
      end
      RS_HOME: begin
        emit_en   = 1'b1;
        emit_byte = rom_byte;
        if (sent) begin
          if (!rom_last) idx_d = idx_q + 2'd1;
`ifdef CONWAY_RENDER_COLOR_EN
          // In colour mode the home sequence is followed by an attribute reset.
          else if (seq_q == SEQ_HOME) begin
            seq_d = SEQ_SGR0;
            idx_d = 2'd0;
          end
`endif
          else state_d = RS_FETCH;
        end
      end
      RS_FETCH: begin
        cell_rd_en = 1'b1;
        state_d    = RS_WAIT;
      end
      RS_WAIT: begin
        cell_d = cell_data;
`ifdef CONWAY_RENDER_COLOR_EN
        if (cell_data != attr_q) begin
          state_d = RS_ATTR;
          seq_d   = cell_data ? SEQ_SGR7 : SEQ_SGR0;
          idx_d   = 2'd0;
        end else begin
          state_d = RS_CELL;
        end
`else
        state_d = RS_CELL;
`endif
      end
`ifdef CONWAY_RENDER_COLOR_EN
      RS_ATTR: begin
        emit_en   = 1'b1;
        emit_byte = rom_byte;
        if (sent) begin
          if (rom_last) begin
            attr_d  = cell_q;
            state_d = RS_CELL;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      RS_TAIL: begin
        emit_en   = 1'b1;
        emit_byte = rom_byte;
        if (sent) begin
          if (rom_last) begin
            attr_d = 1'b0;
            finish = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
`endif
      RS_CELL: begin
        emit_en   = 1'b1;
        emit_byte = cell_q ? CHAR_ALIVE : CHAR_DEAD;
        if (sent) begin
          if (col_q == COL_W'(BOARD_W - 1)) begin
            col_d   = '0;
            idx_d   = 2'd0;
            state_d = RS_EOL;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = RS_FETCH;
          end
        end
      end
      RS_EOL: begin
        emit_en   = 1'b1;
        emit_byte = (idx_q == 2'd0) ? CR : LF;
        if (sent) begin
          if (idx_q == 2'd0) begin
            idx_d = 2'd1;
          end else if (row_q == ROW_W'(BOARD_H - 1)) begin
`ifdef CONWAY_RENDER_COLOR_EN
            if (attr_q) begin
              state_d = RS_TAIL;
              seq_d   = SEQ_SGR0;
              idx_d   = 2'd0;
            end else begin
              finish = 1'b1;
            end
`else
            finish = 1'b1;
`endif
          end else begin
            row_d   = row_q + 1'b1;
            idx_d   = 2'd0;
            state_d = RS_FETCH;
          end
        end
      end
      default: state_d = RS_IDLE;
    endcase

    if (finish) begin
      state_d = RS_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      row_d   = '0;
      col_d   = '0;
    end

    // A byte is loaded only into an empty output register, so it holds steady until accepted.
    if (emit_en) begin
      if (sent) begin
        tx_valid_d = 1'b0;
      end else if (!tx_valid_q) begin
        tx_valid_d = 1'b1;
        tx_data_d  = emit_byte;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RS_IDLE;
      seq_q      <= SEQ_HOME;
      idx_q      <= 2'd0;
      row_q      <= '0;
      col_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
`ifdef CONWAY_RENDER_COLOR_EN
      attr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
`ifdef CONWAY_RENDER_COLOR_EN
      attr_q     <= attr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    cell_q <= cell_d;
  end

endmodule

// File: tb/tb_conway_frame_renderer.sv
// Self-checking bench for conway_frame_renderer on a 4x2 board with a registered-read board RAM model.
// Works in both builds; CONWAY_RENDER_COLOR_EN selects the colour rules in the reference model.
`timescale 1ns/1ps
module tb_conway_frame_renderer;

  localparam int TW = 4;
  localparam int TH = 2;
  localparam int NC = TW * TH;
  localparam int AW = $clog2(NC);
`ifdef CONWAY_RENDER_COLOR_EN
  localparam bit COLOR = 1'b1;
`else
  localparam bit COLOR = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, cell_rd_en, tx_valid;
  logic          cell_data = 1'b0;
  logic          tx_ready = 1'b0;
  logic [AW-1:0] cell_addr;
  logic [7:0]    tx_data;

  logic mem [NC];
  int   checks = 0;
  int   errors = 0;
  bq_t  exp_q;
  int   len_q[$];
  int   rd_log[$];
  int   ready_pct = 100;
  int   hs_in_frame = 0;
  int   done_cnt = 0;

  conway_frame_renderer #(.BOARD_W(TW), .BOARD_H(TH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .cell_rd_en (cell_rd_en),
    .cell_addr  (cell_addr),
    .cell_data  (cell_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (cell_rd_en) begin
      cell_data <= mem[cell_addr];
      rd_log.push_back(int'(cell_addr));
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = ($urandom_range(0, 99) < ready_pct);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the frame as the terminal should receive it, built directly from the board contents.
  task automatic model_frame(input logic [NC-1:0] b, output bq_t q);
    bit attr;
    q.delete();
    q.push_back(8'h1B); q.push_back(8'h5B); q.push_back(8'h48);
    attr = 1'b0;
    if (COLOR) begin
      q.push_back(8'h1B); q.push_back(8'h5B); q.push_back(8'h30); q.push_back(8'h6D);
    end
    for (int r = 0; r < TH; r++) begin
      for (int c = 0; c < TW; c++) begin
        if (COLOR && (b[r*TW+c] != attr)) begin
          q.push_back(8'h1B); q.push_back(8'h5B);
          q.push_back(b[r*TW+c] ? 8'h37 : 8'h30); q.push_back(8'h6D);
          attr = b[r*TW+c];
        end
        q.push_back(b[r*TW+c] ? 8'h2A : 8'h20);
      end
      q.push_back(8'h0D); q.push_back(8'h0A);
    end
    if (COLOR && attr) begin
      q.push_back(8'h1B); q.push_back(8'h5B); q.push_back(8'h30); q.push_back(8'h6D);
    end
  endtask

  task automatic compare_q(input string name, input bq_t got, input bq_t exp);
    int bad;
    bad = -1;
    if (got.size() != exp.size()) bad = 0;
    else for (int i = 0; i < got.size(); i++) if (bad < 0 && got[i] != exp[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: size %0d vs required %0d, first difference at byte %0d", name,
               got.size(), exp.size(), bad);
    end
  endtask

  // Compare process: every accepted byte, hold-while-stalled, and done pulse timing.
  initial begin
    bit         prev_hs, prev_stall, prev_done;
    logic [7:0] prev_data, e;
    prev_hs = 0; prev_stall = 0; prev_done = 0; prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hs = 0; prev_stall = 0; prev_done = 0;
        hs_in_frame = 0;
      end else begin
        if (prev_stall) begin
          chk("tx_valid_held", tx_valid, 1);
          chk("tx_data_held", tx_data, prev_data);
        end
        if (prev_done) chk("done_one_cycle", done, 0);
        if (done) begin
          chk("done_after_last_hs", prev_hs, 1);
          chk("busy_low_in_done", busy, 0);
          if (len_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done with no frame outstanding");
          end else chk("frame_byte_count", hs_in_frame, len_q.pop_front());
          hs_in_frame = 0;
          done_cnt++;
        end
        if (tx_valid && tx_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: got %02h expected none", tx_data);
          end else begin
            e = exp_q.pop_front();
            if (tx_data != e) begin
              errors++;
              $display("FAIL tx_byte: got %02h expected %02h", tx_data, e);
            end
          end
          hs_in_frame++;
        end
        prev_hs    = tx_valid && tx_ready;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_done  = done;
      end
    end
  end

  task automatic set_board(input logic [NC-1:0] b);
    for (int i = 0; i < NC; i++) mem[i] = b[i];
  endtask

  task automatic expect_frame(input logic [NC-1:0] b);
    bq_t q;
    model_frame(b, q);
    foreach (q[i]) exp_q.push_back(q[i]);
    len_q.push_back(q.size());
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 4000 && done_cnt < target; i++) @(negedge clk);
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL done_timeout: got %0d frames expected %0d", done_cnt, target);
    end
  endtask

  task automatic check_reads(input int nframes);
    int bad;
    bad = (rd_log.size() != nframes * NC);
    if (!bad) for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] != (i % NC)) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL cell_addr_sequence: got %0d reads expected %0d in order 0..%0d",
               rd_log.size(), nframes * NC, NC - 1);
    end
  endtask

  task automatic run_frame(input logic [NC-1:0] b, input int pct);
    int target;
    ready_pct = pct;
    set_board(b);
    expect_frame(b);
    rd_log.delete();
    target = done_cnt + 1;
    pulse_start();
    wait_done(target);
    check_reads(1);
  endtask

  initial begin
    bq_t q, lit;
    int unsigned seed;
    int target, d0;
    seed = $urandom(32'd20240);
    set_board('0);

    repeat (3) @(negedge clk);
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_en", cell_rd_en, 0);
    chk("reset_addr", cell_addr, 0);
    chk("reset_tx_data", tx_data, 0);
    rst = 1'b0;

`ifdef CONWAY_RENDER_COLOR_EN
    model_frame(8'h03, q);
    lit = '{8'h1B, 8'h5B, 8'h48, 8'h1B, 8'h5B, 8'h30, 8'h6D,
            8'h1B, 8'h5B, 8'h37, 8'h6D, 8'h2A, 8'h2A, 8'h1B, 8'h5B, 8'h30, 8'h6D, 8'h20, 8'h20, 8'h0D, 8'h0A,
            8'h20, 8'h20, 8'h20, 8'h20, 8'h0D, 8'h0A};
    compare_q("model_color_row0", q, lit);
    model_frame(8'h83, q);
    lit = '{8'h1B, 8'h5B, 8'h48, 8'h1B, 8'h5B, 8'h30, 8'h6D,
            8'h1B, 8'h5B, 8'h37, 8'h6D, 8'h2A, 8'h2A, 8'h1B, 8'h5B, 8'h30, 8'h6D, 8'h20, 8'h20, 8'h0D, 8'h0A,
            8'h20, 8'h20, 8'h20, 8'h1B, 8'h5B, 8'h37, 8'h6D, 8'h2A, 8'h0D, 8'h0A,
            8'h1B, 8'h5B, 8'h30, 8'h6D};
    compare_q("model_color_tail", q, lit);
`else
    model_frame(8'h00, q);
    lit = '{8'h1B, 8'h5B, 8'h48, 8'h20, 8'h20, 8'h20, 8'h20, 8'h0D, 8'h0A,
            8'h20, 8'h20, 8'h20, 8'h20, 8'h0D, 8'h0A};
    compare_q("model_all_dead", q, lit);
    chk("model_len_formula", q.size(), 3 + TH * (TW + 2));
    model_frame(8'hA5, q);
    lit = '{8'h1B, 8'h5B, 8'h48, 8'h2A, 8'h20, 8'h2A, 8'h20, 8'h0D, 8'h0A,
            8'h20, 8'h2A, 8'h20, 8'h2A, 8'h0D, 8'h0A};
    compare_q("model_pattern", q, lit);
`endif

    run_frame(8'h00, 100);
    run_frame(8'hA5, 100);
    run_frame(8'hA5, 50);
    run_frame(8'h03, 60);
    run_frame(8'h83, 100);
    run_frame(8'hFF, 70);
    for (int i = 0; i < 8; i++) run_frame(NC'($urandom), int'($urandom_range(25, 100)));

    // Start pulses during a frame must not queue a second frame.
    ready_pct = 50;
    set_board(8'h5A);
    expect_frame(8'h5A);
    rd_log.delete();
    target = done_cnt + 1;
    pulse_start();
    repeat (8) @(negedge clk);
    chk("busy_mid_frame", busy, 1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(target);
    repeat (40) @(negedge clk);
    chk("ignored_start_busy", busy, 0);
    chk("ignored_start_bytes", hs_in_frame, 0);
    check_reads(1);

    // Start in the done cycle launches the next frame straight away.
    ready_pct = 80;
    set_board(8'h96);
    expect_frame(8'h96);
    expect_frame(8'h96);
    rd_log.delete();
    target = done_cnt + 2;
    pulse_start();
    for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
    chk("b2b_first_done_seen", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_again", busy, 1);
    wait_done(target);
    check_reads(2);

    // Asynchronous reset in the middle of a row.
    ready_pct = 100;
    set_board(8'hA5);
    expect_frame(8'hA5);
    pulse_start();
    for (int i = 0; i < 200 && hs_in_frame < 6; i++) @(negedge clk);
    chk("reset_point_reached", hs_in_frame >= 6, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx_valid", tx_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rd_en", cell_rd_en, 0);
    exp_q.delete();
    len_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_done_after_reset", done_cnt, d0);
    run_frame(8'h00, 100);
    run_frame(8'hA5, 50);

    repeat (5) @(negedge clk);
    chk("expected_bytes_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
